unified_mem_responder: RTL and testbench
========================================

// Module: unified_mem_responder
// PURPOSE
//  Memory-side responder for the pipeline's two memory initiators: instruction fetch (IF) and data load/store (MEM stage).
//  - Serves both from one single-port word array through a req/gnt/rvalid handshake; one access is in flight at a time.
//  - Handles RV32I load/store sizing (funct3), so the core issues byte addresses and receives extended load data.
//  - Replaces the half-rate time-multiplexed shared-memory scheme with an explicit arbitrated responder.
// PARAMETERS
//  ADDR_W       10  word-index width; array holds 2**ADDR_W 32-bit words
//  WAIT_STATES   0  extra cycles inserted between grant and array access (0..15)
// PORTS
//  clk       in   1   clock, rising edge
//  rst       in   1   asynchronous reset, active-high
//  if_req    in   1   fetch request; hold until if_gnt
//  if_addr   in   32  fetch byte address (word aligned)
//  if_gnt    out  1   fetch request accepted this cycle
//  if_rvalid out  1   one-cycle pulse, if_rdata valid
//  if_rdata  out  32  fetched instruction word
//  d_req     in   1   data request; hold until d_gnt
//  d_we      in   1   1=store 0=load
//  d_addr    in   32  data byte address
//  d_func3   in   3   RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  d_wdata   in   32  store data, right-aligned
//  d_gnt     out  1   data request accepted this cycle
//  d_rvalid  out  1   one-cycle pulse: load data valid / store done
//  d_rdata   out  32  extended load data; 0 for stores
//  d_err     out  1   misaligned access, valid with d_rvalid
// BEHAVIOUR
//  Reset (async): state=IDLE, wait counter=0; all outputs 0. Array contents not reset.
//    Reset mid-access aborts it; no rvalid; an uncommitted store never writes.
//  FSM: IDLE -> WAIT (WAIT_STATES>0) -> ACCESS -> RESP -> IDLE.
//    WAIT_STATES=0 skips WAIT.
//  IDLE:
//    - gnt is combinational: asserted only in IDLE with req high.
//    - Request fields are latched on the grant edge.
//    - Data has fixed priority over fetch when both request; the loser keeps req high and is granted on next IDLE.
//  WAIT: 4-bit counter loaded with WAIT_STATES-1; decrements each cycle; at 0 -> ACCESS.
//  ACCESS:
//    - Word index = addr[ADDR_W+1:2]; upper bits ignored (wrap-around).
//    - Store writes byte lanes at this edge.
//    - Load captures the word.
//  RESP: the granted port's rvalid is high for exactly one cycle with registered rdata/err; then IDLE.
//  Latency: gnt in cycle T -> rvalid in T+2+WAIT_STATES.
//    Issue interval is 3+WAIT_STATES cycles; no pipelining.
//  Load extraction:
//    - LB/LBU: byte addr[1:0], sign-/zero-extended.
//    - LH/LHU: half addr[1], sign-/zero-extended.
//    - LW: full word.
//  Store lanes:
//    - SB: d_wdata[7:0] to lane addr[1:0].
//    - SH: d_wdata[15:0] to lanes addr[1]*2..+1.
//    - SW: all lanes.
//  funct3 3/6/7 are treated as LW/SW.
//  Fetch ignores if_addr[1:0]; always a full word; never errors.
//  Store then load of the same address returns the new data; no read-during-write hazard, since accesses are serialized.
// CONFIGURATION
//  Macro: UMR_MISALIGN_TRAP_EN
//  - Defined:
//      - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, sets d_err=1 with d_rvalid.
//      - Such a store writes nothing; such a load returns d_rdata=0.
//  - Undefined:
//      - d_err is tied 0.
//      - Misaligned halves use addr[1] only; misaligned words use addr[1:0]=0 (silent truncation).
// TESTING
//  1. SW 0xDEADBEEF @0x10, then LW/LB/LBU/LH/LHU @0x10, 0x13, 0x13, 0x12, 0x12
//     -> 0xDEADBEEF, 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000DEAD.
//  2. SB 0x7F @0x21 over word 0 -> LW @0x20 = 0x00007F00; SH 0x8001 @0x22 -> LW = 0x80017F00.
//  3. if_req and d_req both high in IDLE
//     -> d_gnt first, if_gnt exactly 3 cycles later (WAIT_STATES=0); if_rdata = word at if_addr.
//  4. WAIT_STATES=3: single LW
//     -> d_rvalid exactly 5 cycles after d_gnt, high for 1 cycle.
//  5. rst pulsed in ACCESS-1 of an SW 0x12345678 @0x40
//     -> no d_rvalid; LW @0x40 returns the old value; outputs 0 during reset.
//  6. With UMR_MISALIGN_TRAP_EN: SW @0x42 -> d_err=1, memory unchanged.
//     Without: the same SW writes word 0x40.

Source files
------------

// File: rtl/unified_mem_responder.sv
// Arbitrated single-port memory responder for instruction fetch and data load/store, with RV32I sizing.
// Optional macro UMR_MISALIGN_TRAP_EN: flag misaligned half/word data accesses on d_err and suppress them.
module unified_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [2:0]  d_func3,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err
);

`ifdef UMR_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    localparam int         Depth    = 2 ** ADDR_W;
    localparam logic [3:0] WaitLoad = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} stateT;

    stateT              state;
    logic [3:0]         waitCnt;
    logic [31:0]        mem [Depth];

    logic               selData;
    logic               weQ;
    logic [ADDR_W-1:0]  idxQ;
    logic [1:0]         offQ;
    logic [2:0]         func3Q;
    logic [31:0]        wdataQ;

    logic [31:0]        rdWord;
    logic               accErr;
    logic               unusedAddrBits;

    // funct3[1:0] selects size: 00 byte, 01 half, else word.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] loadExtend(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] off);
        logic        [7:0]  ub;
        logic        [15:0] uh;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic signed [31:0] sx;
        ub = word[{off, 3'b000} +: 8];
        uh = off[1] ? word[31:16] : word[15:0];
        sb = ub;
        sh = uh;
        case (f3[1:0])
            2'b00: begin
                sx = sb;
                return f3[2] ? {24'b0, ub} : sx;
            end
            2'b01: begin
                sx = sh;
                return f3[2] ? {16'b0, uh} : sx;
            end
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] storeMerge(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] w;
        w = old;
        case (f3[1:0])
            2'b00:   w[{off, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   w[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default: w = wdata;
        endcase
        return w;
    endfunction

    assign unusedAddrBits = ^{if_addr[31:ADDR_W+2], if_addr[1:0], d_addr[31:ADDR_W+2]};

    // Data port wins when both request; the fetch simply stays pending.
    assign d_gnt  = (state == StIdle) && d_req && !rst;
    assign if_gnt = (state == StIdle) && if_req && !d_req && !rst;

    assign rdWord = mem[idxQ];
    assign accErr = TrapEn && selData && misaligned(func3Q, offQ);

    always_ff @(posedge clk) begin
        if (d_gnt) begin
            selData <= 1'b1;
            weQ     <= d_we;
            idxQ    <= d_addr[ADDR_W+1:2];
            offQ    <= d_addr[1:0];
            func3Q  <= d_func3;
            wdataQ  <= d_wdata;
        end else if (if_gnt) begin
            selData <= 1'b0;
            weQ     <= 1'b0;
            idxQ    <= if_addr[ADDR_W+1:2];
            offQ    <= 2'b00;
            func3Q  <= 3'b010;
        end
    end

    // Store commits only at the ACCESS edge; a reset before it leaves the array untouched.
    always_ff @(posedge clk) begin
        if (state == StAccess && selData && weQ && !accErr && !rst)
            mem[idxQ] <= storeMerge(rdWord, wdataQ, func3Q, offQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            waitCnt   <= 4'd0;
            if_rvalid <= 1'b0;
            if_rdata  <= 32'd0;
            d_rvalid  <= 1'b0;
            d_rdata   <= 32'd0;
            d_err     <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (d_gnt || if_gnt) begin
                        if (WAIT_STATES > 0) begin
                            state   <= StWait;
                            waitCnt <= WaitLoad;
                        end else begin
                            state <= StAccess;
                        end
                    end
                end
                StWait: begin
                    if (waitCnt == 4'd0) state <= StAccess;
                    else                 waitCnt <= waitCnt - 4'd1;
                end
                StAccess: begin
                    state <= StResp;
                    if (selData) begin
                        d_rvalid <= 1'b1;
                        d_err    <= accErr;
                        d_rdata  <= (weQ || accErr) ? 32'd0 : loadExtend(rdWord, func3Q, offQ);
                    end else begin
                        if_rvalid <= 1'b1;
                        if_rdata  <= rdWord;
                    end
                end
                StResp: begin
                    state     <= StIdle;
                    if_rvalid <= 1'b0;
                    if_rdata  <= 32'd0;
                    d_rvalid  <= 1'b0;
                    d_rdata   <= 32'd0;
                    d_err     <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_responder.sv
// Self-checking bench: two responders (0 and 3 wait states), vector table, corner sequences, random vs byte-level model.
module tb_unified_mem_responder;

`ifdef UMR_MISALIGN_TRAP_EN
    localparam bit Trap = 1'b1;
`else
    localparam bit Trap = 1'b0;
`endif

    logic        clk;
    logic [1:0]  rst, ifReq, ifGnt, ifRvalid, dReq, dWe, dGnt, dRvalid, dErr;
    logic [31:0] ifAddr [2];
    logic [31:0] ifRdata [2];
    logic [31:0] dAddr [2];
    logic [31:0] dWdata [2];
    logic [31:0] dRdata [2];
    logic [2:0]  dFunc3 [2];

    int checks = 0;
    int errors = 0;

    logic [7:0] shadow [2][128];

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
        logic [31:0] expR;
        bit          expE;
    } vecT;
    vecT tbl[$];

    unified_mem_responder #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst[0]),
        .if_req(ifReq[0]), .if_addr(ifAddr[0]), .if_gnt(ifGnt[0]),
        .if_rvalid(ifRvalid[0]), .if_rdata(ifRdata[0]),
        .d_req(dReq[0]), .d_we(dWe[0]), .d_addr(dAddr[0]), .d_func3(dFunc3[0]),
        .d_wdata(dWdata[0]), .d_gnt(dGnt[0]), .d_rvalid(dRvalid[0]),
        .d_rdata(dRdata[0]), .d_err(dErr[0])
    );

    unified_mem_responder #(.ADDR_W(10), .WAIT_STATES(3)) dut1 (
        .clk(clk), .rst(rst[1]),
        .if_req(ifReq[1]), .if_addr(ifAddr[1]), .if_gnt(ifGnt[1]),
        .if_rvalid(ifRvalid[1]), .if_rdata(ifRdata[1]),
        .d_req(dReq[1]), .d_we(dWe[1]), .d_addr(dAddr[1]), .d_func3(dFunc3[1]),
        .d_wdata(dWdata[1]), .d_gnt(dGnt[1]), .d_rvalid(dRvalid[1]),
        .d_rdata(dRdata[1]), .d_err(dErr[1])
    );

    always #5 clk = ~clk;

    function automatic int ws(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic addVec(input bit we, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] wd, input logic [31:0] er, input bit ee);
        vecT v;
        v.we = we; v.addr = a; v.f3 = f3; v.wdata = wd; v.expR = er; v.expE = ee;
        tbl.push_back(v);
    endtask

    // Byte-addressed little-endian memory; sizes and alignment follow the RV32I rules directly.
    task automatic modelAccess(input int k, input bit isData, input bit we, input logic [31:0] a,
                               input logic [2:0] f3, input logic [31:0] wd,
                               output logic [31:0] expR, output bit expE);
        int sz, base;
        logic [31:0] v;
        expE = 0;
        expR = 0;
        sz = !isData ? 4 : (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (isData && Trap && ((sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00))) begin
            expE = 1;
            return;
        end
        base = (int'(a[6:0]) / sz) * sz;
        if (isData && we) begin
            for (int i = 0; i < sz; i++) shadow[k][base+i] = wd[8*i +: 8];
            return;
        end
        v = 0;
        for (int i = 0; i < sz; i++) v = v | (32'(shadow[k][base+i]) << (8 * i));
        if (isData && sz < 4 && (f3 == 3'd0 || f3 == 3'd1) && v[8*sz-1])
            v = v | (32'hFFFF_FFFF << (8 * sz));
        expR = v;
    endtask

    task automatic doTxn(input int k, input bit isData, input bit we, input logic [31:0] a,
                         input logic [2:0] f3, input logic [31:0] wd,
                         input logic [31:0] expR, input bit expE, input string name);
        int n;
        @(negedge clk);
        if (isData) begin
            dReq[k] = 1; dWe[k] = we; dAddr[k] = a; dFunc3[k] = f3; dWdata[k] = wd;
        end else begin
            ifReq[k] = 1; ifAddr[k] = a;
        end
        #1;
        n = 0;
        while (!(isData ? dGnt[k] : ifGnt[k]) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 20) begin
            chk({name, " gnt timeout"}, 32'd0, 32'd1);
            dReq[k] = 0; ifReq[k] = 0;
            return;
        end
        @(posedge clk); #1;
        dReq[k] = 0; ifReq[k] = 0;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!(isData ? dRvalid[k] : ifRvalid[k]) && n < 40);
        chk({name, " latency"}, n, 2 + ws(k));
        if (isData) begin
            chk({name, " d_rdata"}, dRdata[k], expR);
            chk({name, " d_err"}, dErr[k], expE);
            chk({name, " if_rvalid idle"}, ifRvalid[k], 0);
        end else begin
            chk({name, " if_rdata"}, ifRdata[k], expR);
            chk({name, " d_rvalid idle"}, dRvalid[k], 0);
        end
        @(negedge clk);
        chk({name, " rvalid pulse"}, isData ? dRvalid[k] : ifRvalid[k], 0);
    endtask

    task automatic doModel(input int k, input bit isData, input bit we, input logic [31:0] a,
                           input logic [2:0] f3, input logic [31:0] wd, input string name);
        logic [31:0] er;
        bit ee;
        modelAccess(k, isData, we, a, f3, wd, er, ee);
        doTxn(k, isData, we, a, f3, wd, er, ee, name);
    endtask

    task automatic concurrency(input int k);
        int n, rvAt;
        logic [31:0] dGot;
        doTxn(k, 1, 1, 32'h30, 3'd2, 32'hA5A5_0F0F, 32'd0, 0, "conc setup0");
        doTxn(k, 1, 1, 32'h34, 3'd2, 32'h0BAD_F00D, 32'd0, 0, "conc setup1");
        @(negedge clk);
        dReq[k] = 1; dWe[k] = 0; dAddr[k] = 32'h34; dFunc3[k] = 3'd2;
        ifReq[k] = 1; ifAddr[k] = 32'h32;
        #1;
        chk($sformatf("i%0d conc d_gnt", k), dGnt[k], 1);
        chk($sformatf("i%0d conc if_gnt held", k), ifGnt[k], 0);
        @(posedge clk); #1;
        dReq[k] = 0;
        n = 0; rvAt = -1; dGot = 0;
        do begin
            @(negedge clk); #1; n++;
            if (dRvalid[k]) begin rvAt = n; dGot = dRdata[k]; end
        end while (!ifGnt[k] && n < 20);
        chk($sformatf("i%0d conc if_gnt delay", k), n, 3 + ws(k));
        chk($sformatf("i%0d conc d_rvalid at", k), rvAt, 2 + ws(k));
        chk($sformatf("i%0d conc d_rdata", k), dGot, 32'h0BAD_F00D);
        @(posedge clk); #1;
        ifReq[k] = 0;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!ifRvalid[k] && n < 40);
        chk($sformatf("i%0d conc if latency", k), n, 2 + ws(k));
        chk($sformatf("i%0d conc if_rdata", k), ifRdata[k], 32'hA5A5_0F0F);
    endtask

    task automatic resetAbort(input int k, input int pre);
        int seen;
        doTxn(k, 1, 1, 32'h40, 3'd2, 32'h55AA_55AA, 32'd0, 0, "rst setup");
        @(negedge clk);
        dReq[k] = 1; dWe[k] = 1; dAddr[k] = 32'h40; dFunc3[k] = 3'd2; dWdata[k] = 32'h1234_5678;
        #1;
        chk($sformatf("i%0d rst d_gnt", k), dGnt[k], 1);
        @(posedge clk); #1;
        dReq[k] = 0;
        repeat (pre) @(negedge clk);
        rst[k] = 1;
        #1;
        chk($sformatf("i%0d rst outputs", k),
            {dRvalid[k], dErr[k], ifRvalid[k], dGnt[k], ifGnt[k]}, 0);
        chk($sformatf("i%0d rst d_rdata", k), dRdata[k], 0);
        chk($sformatf("i%0d rst if_rdata", k), ifRdata[k], 0);
        @(negedge clk);
        rst[k] = 0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (dRvalid[k]) seen++;
        end
        chk($sformatf("i%0d rst no rvalid", k), seen, 0);
        doTxn(k, 1, 0, 32'h40, 3'd2, 32'd0, 32'h55AA_55AA, 0, $sformatf("i%0d rst old value", k));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] stF3 [6];
        logic [31:0] a;
        clk = 0;
        rst = 2'b11;
        ifReq = 2'b11; dReq = 2'b11; dWe = 0;
        for (int k = 0; k < 2; k++) begin
            ifAddr[k] = 0; dAddr[k] = 0; dWdata[k] = 0; dFunc3[k] = 0;
        end
        stF3[0] = 3'd0; stF3[1] = 3'd1; stF3[2] = 3'd2;
        stF3[3] = 3'd3; stF3[4] = 3'd6; stF3[5] = 3'd7;

        #12;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("i%0d reset gnts", k), {dGnt[k], ifGnt[k]}, 0);
            chk($sformatf("i%0d reset rvalids", k), {dRvalid[k], ifRvalid[k], dErr[k]}, 0);
            chk($sformatf("i%0d reset d_rdata", k), dRdata[k], 0);
            chk($sformatf("i%0d reset if_rdata", k), ifRdata[k], 0);
        end
        ifReq = 0; dReq = 0;
        @(negedge clk);
        rst = 2'b00;

        addVec(1, 32'h10, 3'd2, 32'hDEAD_BEEF, 32'h0000_0000, 0);
        addVec(0, 32'h10, 3'd2, 32'd0, 32'hDEAD_BEEF, 0);
        addVec(0, 32'h13, 3'd0, 32'd0, 32'hFFFF_FFDE, 0);
        addVec(0, 32'h13, 3'd4, 32'd0, 32'h0000_00DE, 0);
        addVec(0, 32'h12, 3'd1, 32'd0, 32'hFFFF_DEAD, 0);
        addVec(0, 32'h12, 3'd5, 32'd0, 32'h0000_DEAD, 0);
        addVec(0, 32'h10, 3'd0, 32'd0, 32'hFFFF_FFEF, 0);
        addVec(0, 32'h10, 3'd1, 32'd0, 32'hFFFF_BEEF, 0);
        addVec(1, 32'h20, 3'd2, 32'd0, 32'd0, 0);
        addVec(1, 32'h21, 3'd0, 32'h0000_007F, 32'd0, 0);
        addVec(0, 32'h20, 3'd2, 32'd0, 32'h0000_7F00, 0);
        addVec(1, 32'h22, 3'd1, 32'h0000_8001, 32'd0, 0);
        addVec(0, 32'h20, 3'd2, 32'd0, 32'h8001_7F00, 0);
        addVec(1, 32'h40, 3'd2, 32'h1111_2222, 32'd0, 0);
        if (Trap) begin
            addVec(0, 32'h11, 3'd5, 32'd0, 32'd0, 1);
            addVec(0, 32'h12, 3'd7, 32'd0, 32'd0, 1);
            addVec(1, 32'h42, 3'd2, 32'hCAFE_F00D, 32'd0, 1);
            addVec(0, 32'h40, 3'd2, 32'd0, 32'h1111_2222, 0);
        end else begin
            addVec(0, 32'h11, 3'd5, 32'd0, 32'h0000_BEEF, 0);
            addVec(0, 32'h12, 3'd7, 32'd0, 32'hDEAD_BEEF, 0);
            addVec(1, 32'h42, 3'd2, 32'hCAFE_F00D, 32'd0, 0);
            addVec(0, 32'h40, 3'd2, 32'd0, 32'hCAFE_F00D, 0);
        end

        for (int k = 0; k < 2; k++)
            foreach (tbl[i])
                doTxn(k, 1, tbl[i].we, tbl[i].addr, tbl[i].f3, tbl[i].wdata,
                      tbl[i].expR, tbl[i].expE, $sformatf("i%0d vec%0d", k, i));

        for (int k = 0; k < 2; k++) concurrency(k);
        resetAbort(0, 1);
        resetAbort(1, 3);

        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 32; w++)
                doModel(k, 1, 1, 32'(w * 4), 3'd2, $urandom, $sformatf("i%0d init%0d", k, w));
            for (int r = 0; r < 120; r++) begin
                a = {$urandom_range(32'hFFFFF, 0)} << 12;
                a[6:0] = 7'($urandom_range(127, 0));
                if ($urandom_range(3, 0) == 0)
                    doModel(k, 0, 0, a, 3'd2, 32'd0, $sformatf("i%0d rnd%0d fetch", k, r));
                else if ($urandom_range(1, 0) == 1)
                    doModel(k, 1, 1, a, stF3[$urandom_range(5, 0)], $urandom,
                            $sformatf("i%0d rnd%0d store", k, r));
                else
                    doModel(k, 1, 0, a, 3'($urandom_range(7, 0)), 32'd0,
                            $sformatf("i%0d rnd%0d load", k, r));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
